// File: rtl/nibble_serial_adder.sv
// ----------------------------------------------------------------------------
// nibble_serial_adder
//
// Purpose:
//   Adds two W-bit unsigned operands plus a carry-in, where W = 4*NIBBLES.
//   The add uses one 4-bit slice per clock, starting with the least
//   significant nibble. The carry between slices is held in a register.
//   Operands arrive on a valid/ready handshake and the result leaves on a
//   second valid/ready handshake. Only one operation is in flight at a time.
//
// Parameters:
//   NIBBLES     number of 4-bit slices (2..16), W = 4*NIBBLES
//
// Ports:
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   in_valid    operand set present on op_a / op_b / c_in
//   in_ready    block can accept operands (high only in IDLE)
//   op_a, op_b  W-bit unsigned operands
//   c_in        carry into nibble 0
//   out_valid   result present on sum / c_out
//   out_ready   sink accepts result
//   sum         registered low W bits of op_a + op_b + c_in
//   c_out       carry out of the top nibble
//   busy        high while in ADD or DONE
//   ovf         signed two's-complement overflow (only with OVF_DETECT_EN)
//
// Build option:
//   OVF_DETECT_EN  when defined, adds the ovf output and its logic.
// ----------------------------------------------------------------------------
module nibble_serial_adder #(
    parameter int NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [4*NIBBLES-1:0]   op_a,
    input  logic [4*NIBBLES-1:0]   op_b,
    input  logic                   c_in,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [4*NIBBLES-1:0]   sum,
    output logic                   c_out,
`ifdef OVF_DETECT_EN
    output logic                   ovf,
`endif
    output logic                   busy
);

    localparam int W    = 4 * NIBBLES;
    localparam int IDXW = $clog2(NIBBLES);
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NIBBLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q;
    logic [IDXW-1:0] idx_q;
    logic            carry_q;
    logic [W-1:0]    a_q;
    logic [W-1:0]    b_q;
    logic [W-1:0]    sum_q;
    logic            c_out_q;
    logic            out_valid_q;
    logic            in_ready_q;
    logic            busy_q;

    // Latched operands viewed as nibble arrays so the active slice can be
    // selected by idx_q.
    logic [3:0] a_nib [NIBBLES];
    logic [3:0] b_nib [NIBBLES];

    generate
        for (genvar gi = 0; gi < NIBBLES; gi++) begin : g_nib
            assign a_nib[gi] = a_q[gi*4 +: 4];
            assign b_nib[gi] = b_q[gi*4 +: 4];
        end
    endgenerate

    // One 4-bit full-adder slice. Bit 4 is the carry into the next slice.
    logic [4:0] nib_sum_d;
    assign nib_sum_d = {1'b0, a_nib[idx_q]} + {1'b0, b_nib[idx_q]} + {4'b0000, carry_q};

`ifdef OVF_DETECT_EN
    // Signed overflow is the carry into the MSB XOR the carry out of it. The
    // carry into bit 3 of the slice comes from adding its low three bits.
    logic [3:0] low3_d;
    logic       ovf_d;
    logic       ovf_q;
    assign low3_d = {1'b0, a_nib[idx_q][2:0]} + {1'b0, b_nib[idx_q][2:0]} + {3'b000, carry_q};
    assign ovf_d  = low3_d[3] ^ nib_sum_d[4];
    assign ovf    = ovf_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            carry_q     <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            sum_q       <= '0;
            c_out_q     <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
`ifdef OVF_DETECT_EN
            ovf_q       <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid && in_ready_q) begin
                        a_q        <= op_a;
                        b_q        <= op_b;
                        carry_q    <= c_in;
                        // Cleared so the nibbles not yet computed read as 0.
                        sum_q      <= '0;
                        idx_q      <= '0;
                        state_q    <= ADD;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end

                ADD: begin
                    sum_q[{idx_q, 2'b00} +: 4] <= nib_sum_d[3:0];
                    carry_q                    <= nib_sum_d[4];
                    if (idx_q == LAST_IDX) begin
                        c_out_q     <= nib_sum_d[4];
`ifdef OVF_DETECT_EN
                        ovf_q       <= ovf_d;
`endif
                        // Wrap the index here so it never exceeds NIBBLES-1.
                        idx_q       <= '0;
                        state_q     <= DONE;
                        out_valid_q <= 1'b1;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end

                DONE: begin
                    if (out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                    end
                end

                default: begin
                    state_q     <= IDLE;
                    idx_q       <= '0;
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign sum       = sum_q;
    assign c_out     = c_out_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// ----------------------------------------------------------------------------
// tb_nibble_serial_adder
//
// Self-checking bench for nibble_serial_adder with NIBBLES = 4. Each expected
// result is computed from the operands and pushed to a queue when the
// operation is driven. It is popped and compared when the result handshake
// completes. Define OVF_DETECT_EN to also check the ovf output.
// ----------------------------------------------------------------------------
module tb_nibble_serial_adder;

    localparam int NIBBLES = 4;
    localparam int W       = 4 * NIBBLES;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         c_in;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         c_out;
    logic         busy;
`ifdef OVF_DETECT_EN
    logic         ovf;
`endif

    nibble_serial_adder #(.NIBBLES(NIBBLES)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .c_in      (c_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .c_out     (c_out),
`ifdef OVF_DETECT_EN
        .ovf       (ovf),
`endif
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Each entry holds {ovf, c_out, sum}.
    logic [W+1:0] sb_q[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic ci);
        logic [W:0] full;
        logic       v;
        full = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
        // Overflow: both operands share a sign and the result's sign differs.
        v    = (a[W-1] == b[W-1]) && (full[W-1] != a[W-1]);
        return {v, full};
    endfunction

    // The caller is expected to be at posedge+1. Drives one operation, holds
    // off the result for 'stall' cycles, and then accepts the result.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                         input int stall);
        int           cyc;
        logic [W+1:0] exp;
        logic [W+1:0] got;
        cyc = 0;
        while (!in_ready && cyc < 50) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("in_ready_before_op", in_ready, 1);
        op_a      = a;
        op_b      = b;
        c_in      = ci;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        sb_q.push_back(model(a, b, ci));
        @(posedge clk); #1;              // accept edge
        in_valid = 1'b0;
        check("busy_after_accept", busy, 1);
        cyc = 1;
        while (!out_valid && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("out_valid_rise", out_valid, 1);
        check("latency_edges", cyc, NIBBLES + 1);
        for (int s = 0; s < stall; s++) begin
            check("stall_in_ready", in_ready, 0);
            // An operand offered while the result is held must be ignored.
            op_a     = ~a;
            in_valid = (s == 0);
            @(posedge clk); #1;
            in_valid = 1'b0;
            check("stall_out_valid", out_valid, 1);
            if (sb_q.size() > 0)
                check("stall_sum", {c_out, sum}, sb_q[0][W:0]);
        end
        out_ready = 1'b1;
        if (sb_q.size() == 0) begin
            check("scoreboard_empty", 1, 0);
        end else begin
            exp = sb_q.pop_front();
`ifdef OVF_DETECT_EN
            got = {ovf, c_out, sum};
            check("result", got, exp);
`else
            got = {1'b0, c_out, sum};
            check("result", got, {1'b0, exp[W:0]});
`endif
            $display("op a=0x%04h b=0x%04h ci=%0d -> sum=0x%04h c_out=%0d (stall %0d)",
                     a, b, ci, sum, c_out, stall);
        end
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("out_valid_drop", out_valid, 0);
        check("in_ready_after_done", in_ready, 1);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        op_a      = '0;
        op_b      = '0;
        c_in      = 1'b0;
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;

        // 1. Reset asserted mid-cycle takes effect without a clock edge.
        #2 rst_n = 1'b0;
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_sum", sum, 0);
        check("rst_c_out", c_out, 0);
        check("rst_busy", busy, 0);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst_in_ready", in_ready, 1);
        $display("reset test done");

        // 2 and 3. Directed operations, including the ripple-through cases.
        do_op(16'h1234, 16'h1111, 1'b0, 0);
        do_op(16'hFFFF, 16'h0000, 1'b1, 0);
        do_op(16'h8000, 16'h8000, 1'b0, 0);
        do_op(16'h7FFF, 16'h0001, 1'b0, 0);
        do_op(16'hFFFF, 16'h0001, 1'b0, 0);

        // 4. Backpressure for three cycles with an ignored in_valid pulse.
        do_op(16'hABCD, 16'h1357, 1'b1, 3);
        check("bp_busy_idle", busy, 0);

        // 5. Reset during ADD. After two ADD edges the partial sum is 0x0045.
        op_a     = 16'h1234;
        op_b     = 16'h1111;
        c_in     = 1'b0;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("partial_sum", sum, 16'h0045);
        #2 rst_n = 1'b0;
        #1;
        check("midadd_rst_sum", sum, 0);
        check("midadd_rst_busy", busy, 0);
        check("midadd_rst_out_valid", out_valid, 0);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        check("midadd_rst_in_ready", in_ready, 1);
        repeat (8) begin
            @(posedge clk); #1;
            check("no_stale_out_valid", out_valid, 0);
        end
        do_op(16'h00FF, 16'h0001, 1'b0, 0);

        // 6. Randomised operations with random result stalls.
        for (int i = 0; i < 200; i++) begin
            do_op(W'($urandom), W'($urandom), 1'($urandom), int'($urandom_range(0, 3)));
        end

        check("scoreboard_drained", sb_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global watchdog, so the bench always reaches its summary line.
    initial begin
        #200000;
        check("watchdog", 0, 1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
